// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus burst engine.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_SETUP,
        ADDR_STROBE,
        ADDR_HOLD,
        DATA_SETUP,
        DATA_STROBE,
        DATA_HOLD,
        GAP,
        DONE
    } state_t;

    localparam logic MODO_LEER     = 1'b0;
    localparam logic MODO_ESCRIBIR = 1'b1;

    // RTC register map
    localparam logic [7:0] REG_SEGUNDOS = 8'h21;
    localparam logic [7:0] REG_MINUTOS  = 8'h22;
    localparam logic [7:0] REG_HORAS    = 8'h23;
    localparam logic [7:0] REG_DIA      = 8'h24;
    localparam logic [7:0] REG_MES      = 8'h25;
    localparam logic [7:0] REG_ANIO     = 8'h26;
    localparam logic [7:0] REG_COMANDO  = 8'hF0;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; tc is high during the last cycle of a loaded interval.
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val - W'(1);
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/rtc_bus_burst.sv
// Burst engine for the RTC multiplexed address/data bus: runs 1..NUM_REGS
// consecutive register reads or writes with configurable phase widths.
module rtc_bus_burst
    import rtc_bus_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 9,
    parameter int T_PHASE  = 10,
    parameter int T_GAP    = 4,
    localparam int CW      = $clog2(NUM_REGS + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Inicie,
    input  logic              Modo,
    input  logic [ADDR_W-1:0] Dir_base,
    input  logic [CW-1:0]     Cantidad,
    input  logic [DATA_W-1:0] Dato_wr,
    input  logic [DATA_W-1:0] Bus_in,
    output logic [DATA_W-1:0] Bus_out,
    output logic              Bus_oe,
    output logic              CS,
    output logic              AD,
    output logic              RD,
    output logic              WR,
    output logic [CW-1:0]     Indice,
    output logic [DATA_W-1:0] Dato_rd,
    output logic              Dato_rd_valido,
    output logic              Ocupado,
    output logic              Listo
);

    localparam int TMAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PHASE_LEN = TW'(T_PHASE);
    localparam logic [TW-1:0] GAP_LEN   = TW'(T_GAP);

    state_t            state, state_n;
    logic              start, load, tc;
    logic [TW-1:0]     load_val;
    logic              mode_q, mode_n;
    logic [ADDR_W-1:0] base_q, base_n, addr_n;
    logic [CW-1:0]     cnt_q, cnt_clamped, idx_n;
    logic              addr_phase, data_phase, escribir;

    rtc_phase_timer #(.W(TW)) u_timer (
        .clock    (Clock),
        .reset    (Reset),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    assign cnt_clamped = (Cantidad > CW'(NUM_REGS)) ? CW'(NUM_REGS) : Cantidad;

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        load     = 1'b0;
        load_val = PHASE_LEN;
        idx_n    = Indice;
        case (state)
            IDLE: if (Inicie) begin
                start = 1'b1;
                idx_n = '0;
                if (Cantidad != '0) begin
                    state_n = ADDR_SETUP;
                    load    = 1'b1;
                end else begin
                    state_n = DONE;
                end
            end
            ADDR_SETUP:  if (tc) begin state_n = ADDR_STROBE; load = 1'b1; end
            ADDR_STROBE: if (tc) begin state_n = ADDR_HOLD;   load = 1'b1; end
            ADDR_HOLD:   if (tc) begin state_n = DATA_SETUP;  load = 1'b1; end
            DATA_SETUP:  if (tc) begin state_n = DATA_STROBE; load = 1'b1; end
            DATA_STROBE: if (tc) begin state_n = DATA_HOLD;   load = 1'b1; end
            DATA_HOLD: if (tc) begin
                state_n  = GAP;
                load     = 1'b1;
                load_val = GAP_LEN;
            end
            GAP: if (tc) begin
                if (Indice == cnt_q - CW'(1)) begin
                    state_n = DONE;
                end else begin
                    state_n = ADDR_SETUP;
                    load    = 1'b1;
                    idx_n   = Indice + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so pins change with the state.
    assign mode_n     = start ? Modo : mode_q;
    assign base_n     = start ? Dir_base : base_q;
    assign addr_n     = base_n + ADDR_W'(idx_n);
    assign escribir   = (mode_n == MODO_ESCRIBIR);
    assign addr_phase = (state_n == ADDR_SETUP) || (state_n == ADDR_STROBE) ||
                        (state_n == ADDR_HOLD);
    assign data_phase = (state_n == DATA_SETUP) || (state_n == DATA_STROBE) ||
                        (state_n == DATA_HOLD);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            mode_q         <= MODO_LEER;
            base_q         <= '0;
            cnt_q          <= '0;
            Indice         <= '0;
            CS             <= 1'b1;
            AD             <= 1'b1;
            RD             <= 1'b1;
            WR             <= 1'b1;
            Bus_oe         <= 1'b0;
            Bus_out        <= '0;
            Dato_rd        <= '0;
            Dato_rd_valido <= 1'b0;
            Ocupado        <= 1'b0;
            Listo          <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            base_q <= base_n;
            Indice <= idx_n;
            if (start)
                cnt_q <= cnt_clamped;

            CS     <= ~(addr_phase || data_phase);
            AD     <= ~addr_phase;
            WR     <= ~((state_n == ADDR_STROBE) || ((state_n == DATA_STROBE) && escribir));
            RD     <= ~((state_n == DATA_STROBE) && !escribir);
            Bus_oe <= addr_phase || (data_phase && escribir);

            // Address and write data are each sampled once, on phase entry.
            if (state_n == ADDR_SETUP && state != ADDR_SETUP)
                Bus_out <= DATA_W'(addr_n);
            else if (state_n == DATA_SETUP && state != DATA_SETUP && escribir)
                Bus_out <= Dato_wr;

            Dato_rd_valido <= 1'b0;
            if (state == DATA_STROBE && tc && mode_q == MODO_LEER) begin
                Dato_rd        <= Bus_in;
                Dato_rd_valido <= 1'b1;
            end

            Listo <= (state == DONE);
            if (start)
                Ocupado <= 1'b1;
            else if (state == DONE)
                Ocupado <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtc_bus_burst.sv
// Scoreboard bench for rtc_bus_burst: expected bus strobes, read captures and
// Listo times are queued at Inicie and consumed as the DUT produces them.
module tb_rtc_bus_burst;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 9;
    localparam int T_PHASE  = 2;
    localparam int T_GAP    = 1;
    localparam int CW       = $clog2(NUM_REGS + 1);
    localparam int REG_CYC  = 6 * T_PHASE + T_GAP;

    logic              Clock, Reset, Inicie, Modo;
    logic [ADDR_W-1:0] Dir_base;
    logic [CW-1:0]     Cantidad;
    logic [DATA_W-1:0] Dato_wr, Bus_in, Bus_out, Dato_rd;
    logic              Bus_oe, CS, AD, RD, WR, Dato_rd_valido, Ocupado, Listo;
    logic [CW-1:0]     Indice;

    rtc_bus_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .T_PHASE(T_PHASE), .T_GAP(T_GAP)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Inicie(Inicie), .Modo(Modo),
        .Dir_base(Dir_base), .Cantidad(Cantidad), .Dato_wr(Dato_wr),
        .Bus_in(Bus_in), .Bus_out(Bus_out), .Bus_oe(Bus_oe), .CS(CS),
        .AD(AD), .RD(RD), .WR(WR), .Indice(Indice), .Dato_rd(Dato_rd),
        .Dato_rd_valido(Dato_rd_valido), .Ocupado(Ocupado), .Listo(Listo)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cycle = 0;
    always @(posedge Clock) cycle <= cycle + 1;

    // Device model: latches the address on the address strobe and answers
    // reads with 0xA in the high nibble and the address low nibble below.
    logic [7:0] devAddr = 8'h00;
    always @(posedge Clock)
        if (!CS && !AD && !WR) devAddr <= Bus_out;
    assign Bus_in  = {4'hA, devAddr[3:0]};
    assign Dato_wr = 8'h55 + {4'b0000, Indice};

    int checks = 0;
    int fails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0]  expWrQ[$];
    logic [11:0] expRdQ[$];
    int          expListoQ[$];

    logic        monEn = 1'b0;
    logic        prevWR = 1'b1;
    int          wrLen = 0, rdLowCycles = 0, csLowCycles = 0, listoCount = 0, validCount = 0;
    logic [7:0]  ew;
    logic [11:0] er;
    int          el;

    always @(negedge Clock) begin
        if (monEn) begin
            if (!CS) csLowCycles++;
            if (!RD) begin
                rdLowCycles++;
                checkOutput("rd_oe", 32'(Bus_oe), 32'd0);
            end
            if (!WR) begin
                wrLen++;
                if (prevWR) begin
                    if (expWrQ.size() == 0) checkOutput("wr_unexpected", 32'd1, 32'd0);
                    else begin
                        ew = expWrQ.pop_front();
                        checkOutput("wr_bus", 32'(Bus_out), 32'(ew));
                    end
                    checkOutput("wr_oe", 32'(Bus_oe), 32'd1);
                end
            end else if (!prevWR) begin
                checkOutput("wr_len", 32'(wrLen), 32'(T_PHASE));
                wrLen = 0;
            end
            prevWR = WR;
            if (Dato_rd_valido) begin
                validCount++;
                if (expRdQ.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
                else begin
                    er = expRdQ.pop_front();
                    checkOutput("rd_data", 32'(Dato_rd), 32'(er[7:0]));
                    checkOutput("rd_idx", 32'(Indice), 32'(er[11:8]));
                end
            end
            if (Listo) begin
                listoCount++;
                if (expListoQ.size() == 0) checkOutput("listo_unexpected", 32'd1, 32'd0);
                else begin
                    el = expListoQ.pop_front();
                    checkOutput("listo_cycle", 32'(cycle), 32'(el));
                end
            end
        end
    end

    // Called at posedge+1; issues one Inicie and queues every expected event.
    task automatic applyStimulus(input logic modo, input logic [7:0] base, input logic [CW-1:0] cant);
        int n;
        logic [7:0] a;
        logic [3:0] ii;
        Modo = modo; Dir_base = base; Cantidad = cant; Inicie = 1'b1;
        @(posedge Clock); #1;
        Inicie = 1'b0;
        n = (int'(cant) > NUM_REGS) ? NUM_REGS : int'(cant);
        expListoQ.push_back(cycle + n * REG_CYC + 1);
        for (int i = 0; i < n; i++) begin
            a  = base + 8'(i);
            ii = 4'(i);
            expWrQ.push_back(a);
            if (modo) expWrQ.push_back(8'h55 + 8'(i));
            else      expRdQ.push_back({ii, 4'hA, a[3:0]});
        end
        checkOutput("ocupado_start", 32'(Ocupado), 32'd1);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (expListoQ.size() != 0 && n < budget) begin
            @(posedge Clock); #1;
            n++;
        end
        checkOutput("listo_pending", 32'(expListoQ.size()), 32'd0);
        repeat (6) begin @(posedge Clock); #1; end
        checkOutput("ocupado_end", 32'(Ocupado), 32'd0);
        checkOutput("wrq_empty", 32'(expWrQ.size()), 32'd0);
        checkOutput("rdq_empty", 32'(expRdQ.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, lc, vc;
        Reset = 1'b1; Inicie = 1'b0; Modo = 1'b0; Dir_base = '0; Cantidad = '0;
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("rst_cs", 32'(CS), 32'd1);
        checkOutput("rst_ad", 32'(AD), 32'd1);
        checkOutput("rst_rd", 32'(RD), 32'd1);
        checkOutput("rst_wr", 32'(WR), 32'd1);
        checkOutput("rst_oe", 32'(Bus_oe), 32'd0);
        checkOutput("rst_bus", 32'(Bus_out), 32'd0);
        checkOutput("rst_idx", 32'(Indice), 32'd0);
        checkOutput("rst_dato", 32'(Dato_rd), 32'd0);
        checkOutput("rst_valid", 32'(Dato_rd_valido), 32'd0);
        checkOutput("rst_ocup", 32'(Ocupado), 32'd0);
        checkOutput("rst_listo", 32'(Listo), 32'd0);
        Reset = 1'b0;
        monEn = 1'b1;
        @(posedge Clock); #1;

        $display("[TB] read burst of 3 from 0x21");
        validCount = 0; listoCount = 0;
        applyStimulus(1'b0, 8'h21, 4'd3);
        waitDone(200);
        checkOutput("rd3_valid_cnt", 32'(validCount), 32'd3);
        checkOutput("rd3_listo_cnt", 32'(listoCount), 32'd1);

        $display("[TB] write burst of 2 to 0x10");
        validCount = 0; rdLowCycles = 0;
        applyStimulus(1'b1, 8'h10, 4'd2);
        waitDone(200);
        checkOutput("wr2_rd_low", 32'(rdLowCycles), 32'd0);
        checkOutput("wr2_valid_cnt", 32'(validCount), 32'd0);

        $display("[TB] zero-length burst");
        csLowCycles = 0;
        applyStimulus(1'b0, 8'h30, 4'd0);
        waitDone(20);
        checkOutput("zero_cs_low", 32'(csLowCycles), 32'd0);

        $display("[TB] oversize burst clamped");
        validCount = 0;
        applyStimulus(1'b0, 8'h30, 4'd15);
        waitDone(400);
        checkOutput("clamp_valid_cnt", 32'(validCount), 32'(NUM_REGS));

        $display("[TB] address wrap");
        applyStimulus(1'b0, 8'hFF, 4'd2);
        waitDone(200);

        $display("[TB] Inicie and Modo disturbed mid-burst");
        listoCount = 0; validCount = 0;
        applyStimulus(1'b0, 8'h40, 4'd2);
        repeat (5) begin @(posedge Clock); #1; end
        Inicie = 1'b1; Modo = 1'b1; Dir_base = 8'h77; Cantidad = 4'd5;
        repeat (3) begin @(posedge Clock); #1; end
        Inicie = 1'b0; Modo = 1'b0;
        waitDone(200);
        checkOutput("dist_listo_cnt", 32'(listoCount), 32'd1);
        checkOutput("dist_valid_cnt", 32'(validCount), 32'd2);

        $display("[TB] reset during data strobe");
        applyStimulus(1'b0, 8'h50, 4'd2);
        n = 0;
        while (RD !== 1'b0 && n < 200) begin @(posedge Clock); #1; n++; end
        checkOutput("reach_strobe", 32'(RD), 32'd0);
        lc = listoCount; vc = validCount;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        expWrQ.delete(); expRdQ.delete(); expListoQ.delete();
        checkOutput("abort_cs", 32'(CS), 32'd1);
        checkOutput("abort_rd", 32'(RD), 32'd1);
        checkOutput("abort_oe", 32'(Bus_oe), 32'd0);
        checkOutput("abort_ocup", 32'(Ocupado), 32'd0);
        repeat (40) begin @(posedge Clock); #1; end
        checkOutput("abort_no_listo", 32'(listoCount), 32'(lc));
        checkOutput("abort_no_valid", 32'(validCount), 32'(vc));
        applyStimulus(1'b0, 8'h60, 4'd1);
        waitDone(200);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
